// File: rtl/mips_bus_arbiter_if.sv
// Purpose: groups the two requester ports and the shared memory-bus port
//          of mips_bus_arbiter into one bundle.
// Signals:
//   m0_* / m1_* : requester-side Avalon-MM (address, read, write, writedata,
//                 byteenable in; readdata, waitrequest out of the arbiter)
//   s_*         : shared-bus side (command out of the arbiter;
//                 readdata, waitrequest in from the slave)
// Modports:
//   arbiter : the view used by mips_bus_arbiter
//   master  : the two CPU-side requesters
//   slave   : the memory/peripheral on the shared bus
interface mips_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [BE_W-1:0]   m0_byteenable;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_waitrequest;

    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [BE_W-1:0]   m1_byteenable;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_waitrequest;

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic [DATA_W-1:0] s_readdata;
    logic              s_waitrequest;

    modport arbiter (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_readdata, m0_waitrequest,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_readdata, m1_waitrequest,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_readdata, s_waitrequest
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_readdata, m0_waitrequest,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_readdata, m1_waitrequest
    );

    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_readdata, s_waitrequest
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Purpose: two-requester arbiter (M0 = instruction fetch, M1 = data) in
//          front of the single Avalon-style memory bus of mips_cpu_bus.
//          The winning command is registered onto the bus and held until
//          the slave drops waitrequest; a sticky flag reports long stalls.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low reset
//   bus       : mips_bus_arbiter_if.arbiter (requester and shared-bus signals)
//   grant     : one-hot owner, bit0 = M0, bit1 = M1, 00 when idle
//   bus_error : sticky slave-timeout flag
// Parameters:
//   FIXED_PRIORITY : 0 = round-robin, 1 = M1 wins every tie
//   TIMEOUT        : stall cycles in a busy state before bus_error; 0 disables
module mips_bus_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_bus_arbiter_if.arbiter        bus,
    output logic [1:0]                 grant,
    output logic                       bus_error
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic              read;
        logic              write;
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [1:0]        grant_q, grant_d;
    logic              rr_m1_q, rr_m1_d;    // 1: M1 wins the next tie
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              m0_req_c, m1_req_c, pick_m1_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    cmd_t              m0_cmd_c, m1_cmd_c;

    // Requests and normalised commands; read+write together means write.
    always_comb begin
        m0_req_c = bus.m0_read | bus.m0_write;
        m1_req_c = bus.m1_read | bus.m1_write;

        m0_cmd_c.address    = bus.m0_address;
        m0_cmd_c.writedata  = bus.m0_writedata;
        m0_cmd_c.byteenable = bus.m0_byteenable;
        m0_cmd_c.write      = bus.m0_write;
        m0_cmd_c.read       = bus.m0_read & ~bus.m0_write;

        m1_cmd_c.address    = bus.m1_address;
        m1_cmd_c.writedata  = bus.m1_writedata;
        m1_cmd_c.byteenable = bus.m1_byteenable;
        m1_cmd_c.write      = bus.m1_write;
        m1_cmd_c.read       = bus.m1_read & ~bus.m1_write;

        // M1 wins alone, or on a tie under fixed priority / its round-robin turn.
        pick_m1_c = m1_req_c & (~m0_req_c | (FIXED_PRIORITY != 0) | rr_m1_q);

        cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        grant_d = grant_q;
        rr_m1_d = rr_m1_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                cnt_d       = '0;
                cmd_d.read  = 1'b0;
                cmd_d.write = 1'b0;
                grant_d     = 2'b00;
                if (m0_req_c | m1_req_c) begin
                    if (pick_m1_c) begin
                        state_d = BUSY1;
                        cmd_d   = m1_cmd_c;
                        grant_d = 2'b10;
                        rr_m1_d = 1'b0;
                    end else begin
                        state_d = BUSY0;
                        cmd_d   = m0_cmd_c;
                        grant_d = 2'b01;
                        rr_m1_d = 1'b1;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (!bus.s_waitrequest) begin
                    state_d     = IDLE;
                    cmd_d.read  = 1'b0;
                    cmd_d.write = 1'b0;
                    grant_d     = 2'b00;
                end else begin
                    // Stalls are only flagged; the transaction keeps waiting.
                    cnt_d = cnt_inc_c;
                    if ((TIMEOUT != 0) && (32'(cnt_inc_c) >= TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_d.read  = 1'b0;
                cmd_d.write = 1'b0;
                grant_d     = 2'b00;
            end
        endcase
    end

    // State register; reset abandons any in-flight command immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            grant_q <= 2'b00;
            rr_m1_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            grant_q <= grant_d;
            rr_m1_q <= rr_m1_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_address    = cmd_q.address;
    assign bus.s_writedata  = cmd_q.writedata;
    assign bus.s_byteenable = cmd_q.byteenable;
    assign bus.s_read       = cmd_q.read;
    assign bus.s_write      = cmd_q.write;
    assign grant            = grant_q;
    assign bus_error        = err_q;

    // Requester responses pass straight through from the slave for the owner.
    assign bus.m0_waitrequest = (state_q == BUSY0) ? bus.s_waitrequest : 1'b1;
    assign bus.m1_waitrequest = (state_q == BUSY1) ? bus.s_waitrequest : 1'b1;
    assign bus.m0_readdata    = ((state_q == BUSY0) && !bus.s_waitrequest && cmd_q.read)
                                ? bus.s_readdata : '0;
    assign bus.m1_readdata    = ((state_q == BUSY1) && !bus.s_waitrequest && cmd_q.read)
                                ? bus.s_readdata : '0;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench: a round-robin instance (TIMEOUT=4) and a fixed-priority
// instance (default TIMEOUT) share clock and reset.
module tb_mips_bus_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] grant_rr, grant_fp;
    logic       err_rr, err_fp;

    int checks = 0;
    int errors = 0;

    mips_bus_arbiter_if bus_rr ();
    mips_bus_arbiter_if bus_fp ();

    mips_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT(4)) dut_rr (
        .clk(clk), .reset(reset), .bus(bus_rr), .grant(grant_rr), .bus_error(err_rr)
    );

    mips_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT(255)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp), .grant(grant_fp), .bus_error(err_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;

        reset = 1'b0;
        bus_rr.m0_address = '0; bus_rr.m0_read = 0; bus_rr.m0_write = 0;
        bus_rr.m0_writedata = '0; bus_rr.m0_byteenable = '0;
        bus_rr.m1_address = '0; bus_rr.m1_read = 0; bus_rr.m1_write = 0;
        bus_rr.m1_writedata = '0; bus_rr.m1_byteenable = '0;
        bus_rr.s_readdata = '0; bus_rr.s_waitrequest = 0;
        bus_fp.m0_address = '0; bus_fp.m0_read = 0; bus_fp.m0_write = 0;
        bus_fp.m0_writedata = '0; bus_fp.m0_byteenable = '0;
        bus_fp.m1_address = '0; bus_fp.m1_read = 0; bus_fp.m1_write = 0;
        bus_fp.m1_writedata = '0; bus_fp.m1_byteenable = '0;
        bus_fp.s_readdata = '0; bus_fp.s_waitrequest = 0;

        cyc(); cyc();
        chk("rst_s_read", bus_rr.s_read, 0);
        chk("rst_s_write", bus_rr.s_write, 0);
        chk("rst_s_address", bus_rr.s_address, 0);
        chk("rst_grant", grant_rr, 0);
        chk("rst_bus_error", err_rr, 0);
        chk("rst_m0_wait", bus_rr.m0_waitrequest, 1);
        chk("rst_m0_rdata", bus_rr.m0_readdata, 0);

        // Single zero-wait M0 fetch right after reset release.
        reset = 1'b1;
        bus_rr.m0_address = 32'hBFC0_0000; bus_rr.m0_read = 1;
        bus_rr.s_readdata = 32'h8C01_0004; bus_rr.s_waitrequest = 0;
        #1;
        chk("t1_idle_grant", grant_rr, 0);
        chk("t1_idle_m0_wait", bus_rr.m0_waitrequest, 1);
        cyc();
        chk("t1_s_read", bus_rr.s_read, 1);
        chk("t1_s_address", bus_rr.s_address, 32'hBFC0_0000);
        chk("t1_grant", grant_rr, 2'b01);
        chk("t1_m0_rdata", bus_rr.m0_readdata, 32'h8C01_0004);
        chk("t1_m0_wait", bus_rr.m0_waitrequest, 0);
        chk("t1_m1_wait", bus_rr.m1_waitrequest, 1);
        bus_rr.m0_read = 0;
        cyc();
        chk("t1_turn_s_read", bus_rr.s_read, 0);
        chk("t1_turn_grant", grant_rr, 0);
        chk("t1_turn_m0_rdata", bus_rr.m0_readdata, 0);

        // M1 write stalled for three cycles.
        bus_rr.m1_address = 32'h8; bus_rr.m1_write = 1;
        bus_rr.m1_writedata = 32'h5C3A_18FC; bus_rr.m1_byteenable = 4'hF;
        bus_rr.s_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_stall_s_write", bus_rr.s_write, 1);
            chk("t2_stall_wdata", bus_rr.s_writedata, 32'h5C3A_18FC);
            chk("t2_stall_grant", grant_rr, 2'b10);
            chk("t2_stall_m1_wait", bus_rr.m1_waitrequest, 1);
        end
        cyc();
        bus_rr.s_waitrequest = 0;
        #1;
        chk("t2_done_s_write", bus_rr.s_write, 1);
        chk("t2_done_be", bus_rr.s_byteenable, 4'hF);
        chk("t2_done_m1_wait", bus_rr.m1_waitrequest, 0);
        chk("t2_done_m1_rdata", bus_rr.m1_readdata, 0);
        bus_rr.m1_write = 0;
        cyc();
        chk("t2_turn_s_write", bus_rr.s_write, 0);
        chk("t2_bus_error", err_rr, 0);

        // Round-robin with both requesting continuously.
        bus_rr.m0_address = 32'h100; bus_rr.m0_read = 1;
        bus_rr.m1_address = 32'h200; bus_rr.m1_read = 1;
        bus_rr.s_waitrequest = 0; bus_rr.s_readdata = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            cyc();
            chk("t3_grant", grant_rr, exp_g);
            chk("t3_s_address", bus_rr.s_address, (i % 2 == 0) ? 32'h100 : 32'h200);
            if (exp_g == 2'b01) chk("t3_loser_m1_wait", bus_rr.m1_waitrequest, 1);
            else                chk("t3_loser_m0_wait", bus_rr.m0_waitrequest, 1);
            cyc();
            chk("t3_turn_grant", grant_rr, 0);
            chk("t3_turn_m0_wait", bus_rr.m0_waitrequest, 1);
            chk("t3_turn_m1_wait", bus_rr.m1_waitrequest, 1);
        end
        bus_rr.m0_read = 0; bus_rr.m1_read = 0;

        // Timeout after four stall cycles; flag is sticky.
        bus_rr.m0_address = 32'h40; bus_rr.m0_read = 1; bus_rr.s_waitrequest = 1;
        cyc();
        chk("t5_grant", grant_rr, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_err_before", err_rr, 0);
        end
        cyc();
        chk("t5_err_set", err_rr, 1);
        chk("t5_still_busy", grant_rr, 2'b01);
        bus_rr.s_waitrequest = 0;
        bus_rr.m0_read = 0;
        cyc();
        chk("t5_done_grant", grant_rr, 0);
        chk("t5_err_sticky", err_rr, 1);
        cyc();
        chk("t5_err_sticky2", err_rr, 1);

        // Reset mid-BUSY1 write, then check the first tie goes to M0.
        bus_rr.m1_address = 32'hC; bus_rr.m1_write = 1;
        bus_rr.m1_writedata = 32'h11; bus_rr.m1_byteenable = 4'h3;
        bus_rr.s_waitrequest = 1;
        cyc();
        chk("t6_busy_s_write", bus_rr.s_write, 1);
        chk("t6_busy_grant", grant_rr, 2'b10);
        reset = 1'b0;
        #1;
        chk("t6_rst_s_write", bus_rr.s_write, 0);
        chk("t6_rst_grant", grant_rr, 0);
        chk("t6_rst_err", err_rr, 0);
        bus_rr.m1_write = 0;
        cyc();
        reset = 1'b1;
        bus_rr.m0_address = 32'h300; bus_rr.m0_read = 1;
        bus_rr.m1_address = 32'h400; bus_rr.m1_read = 1;
        bus_rr.s_waitrequest = 0;
        #1;
        chk("t6_idle_grant", grant_rr, 0);
        cyc();
        chk("t6_tie_grant", grant_rr, 2'b01);
        chk("t6_tie_addr", bus_rr.s_address, 32'h300);
        bus_rr.m0_read = 0; bus_rr.m1_read = 0;
        cyc();

        // Fixed priority: M1 always wins, M0 served once M1 drops.
        bus_fp.m0_address = 32'hA0; bus_fp.m0_read = 1;
        bus_fp.m1_address = 32'hB0; bus_fp.m1_read = 1;
        bus_fp.s_waitrequest = 0; bus_fp.s_readdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_grant_m1", grant_fp, 2'b10);
            chk("t4_m0_wait", bus_fp.m0_waitrequest, 1);
            chk("t4_m1_rdata", bus_fp.m1_readdata, 32'hCAFE_0001);
            cyc();
            chk("t4_turn_grant", grant_fp, 0);
            chk("t4_turn_m0_wait", bus_fp.m0_waitrequest, 1);
        end
        bus_fp.m1_read = 0;
        cyc();
        chk("t4_grant_m0", grant_fp, 2'b01);
        chk("t4_m0_addr", bus_fp.s_address, 32'hA0);
        chk("t4_m0_wait_done", bus_fp.m0_waitrequest, 0);
        chk("t4_m0_rdata", bus_fp.m0_readdata, 32'hCAFE_0001);
        chk("t4_err_fp", err_fp, 0);
        bus_fp.m0_read = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
